deca_vip_led_pio: RTL and testbench
===================================

Name: deca_vip_led_pio

Overview:
- Avalon-MM output PIO: the write-side counterpart of the switch input PIO. Nios II software drives board LEDs and other output pins through it.
- Holds an output data register with atomic set and clear aliases.
- Adds a hardware blink engine, so selected bits toggle at a programmable rate with no CPU involvement.
- Sits on the system interconnect beside the switch PIO. Same register-read timing: read latency 1.

Parameters:
DATA_WIDTH, 8, number of output bits (1..32)
RESET_VALUE, 0, value loaded into DATA and driven on out_port at reset
PERIOD_W, 24, width of the blink half-period register and counter (1..32)
PERIOD_RESET, 12500000, reset value of BLINK_PERIOD (0.25 s half-period at 50 MHz)

Ports:
clk  input  1  system clock; all logic on its rising edge
reset  input  1  synchronous, active-high reset
address  input  3  word address of the register
chipselect  input  1  slave select
write_n  input  1  active-low write strobe; valid only with chipselect=1
writedata  input  32  write data
readdata  output  32  registered read data
out_port  output  DATA_WIDTH  registered output pins

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on port reset.
- Register map:
  - 0 DATA: R/W.
  - 1 BLINK_EN: R/W, per-bit blink mask.
  - 2 BLINK_PERIOD: R/W, PERIOD_W bits.
  - 3 STATUS: RO, bit0 = blink phase.
  - 4 OUTSET: WO.
  - 5 OUTCLEAR: WO.
  - 6 and 7: reserved; read 0, writes ignored.
- Write: takes effect on the clk edge where chipselect=1 and write_n=0. Only writedata[DATA_WIDTH-1:0] is used (PERIOD_W bits for BLINK_PERIOD); upper bits are ignored.
- OUTSET: DATA <= DATA | wd.
- OUTCLEAR: DATA <= DATA & ~wd.
- Read:
  - readdata is registered every cycle from address, independent of chipselect. Valid the cycle after address is presented (latency 1).
  - Unused upper bits read 0.
  - OUTSET, OUTCLEAR and reserved addresses read 0.
- Blink engine:
  - counter (PERIOD_W bits) increments every cycle.
  - When counter == BLINK_PERIOD: counter <= 0 and phase <= ~phase.
  - BLINK_PERIOD = N gives a half-period of N+1 cycles; N = 0 toggles phase every cycle.
- Any write to BLINK_PERIOD, including the same value, clears counter to 0 and phase to 0 on that edge. Comparison uses the new value from the next cycle.
- If BLINK_PERIOD is written below the current counter, the restart above prevents a 2^PERIOD_W wrap.
- Output, registered: out_port <= DATA_next ^ (BLINK_EN_next & {DATA_WIDTH{phase_next}}).
  - A DATA/SET/CLEAR/BLINK_EN write is visible on out_port exactly 1 cycle after the write edge.
  - A phase toggle is visible 1 cycle after the toggle edge.
- Clearing a BLINK_EN bit returns that pin to its DATA value 1 cycle later, regardless of phase.
- Simultaneous phase toggle and any register write on the same edge: both take effect. out_port reflects both after one cycle.
- Reset (synchronous, also mid-operation): DATA = RESET_VALUE, BLINK_EN = 0, BLINK_PERIOD = PERIOD_RESET, counter = 0, phase = 0, readdata = 0, out_port = RESET_VALUE.
- A write coincident with reset is discarded.
- No wait states, no waitrequest.

Test Plan:
- Reset: assert reset 2 cycles, then release -> out_port=0x00, readdata=0, and a read of addr 2 returns 12500000 (0x00BEBC20).
- DATA write and readback: write 0xA5 to addr 0 -> out_port=0xA5 one cycle later. Read addr 0 -> readdata=0x000000A5 one cycle after address. Write 0xFFFFFF3C -> out_port=0x3C.
- Set/clear: starting from DATA=0xA5, write 0x0A to OUTSET -> DATA=0xAF. Then write 0x81 to OUTCLEAR -> DATA=0x2E. Reads of addr 4/5/6 return 0.
- Blink timing: DATA=0x00, BLINK_PERIOD=3, BLINK_EN=0x01 -> out_port[0] toggles every 4 cycles; STATUS bit0 tracks phase; other bits stay 0. BLINK_PERIOD=0 -> out_port[0] toggles every cycle.
- Blink interactions:
  - Rewrite BLINK_PERIOD mid-half-period -> phase=0 and counter restarts; next toggle occurs N+1 cycles later.
  - Clear BLINK_EN while phase=1 -> pin returns to its DATA bit next cycle.
  - DATA write on a toggle edge -> both reflected.
- Reset mid-blink: with phase=1, BLINK_EN=0xFF, assert reset for 1 cycle -> next cycle out_port=RESET_VALUE, STATUS=0, BLINK_EN reads 0.

Source files
------------

// File: rtl/deca_vip_led_pio.sv
// deca_vip_led_pio: Avalon-MM output PIO with atomic set/clear aliases and a
// hardware blink engine.
//
// Ports:
//   clk         system clock, all logic on the rising edge
//   reset       synchronous, active-high reset
//   address     register word address (0 DATA, 1 BLINK_EN, 2 BLINK_PERIOD,
//               3 STATUS, 4 OUTSET, 5 OUTCLEAR, 6/7 reserved)
//   chipselect  slave select
//   write_n     active-low write strobe, qualified by chipselect
//   writedata   write data (only the low register-width bits are used)
//   readdata    registered read data, latency 1, independent of chipselect
//   out_port    registered output pins: DATA ^ (BLINK_EN & phase)
module deca_vip_led_pio #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned RESET_VALUE  = 0,
  parameter int unsigned PERIOD_W     = 24,
  parameter int unsigned PERIOD_RESET = 12500000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] out_port
);

  localparam logic [31:0]           ResetValue32  = 32'(RESET_VALUE);
  localparam logic [31:0]           PeriodReset32 = 32'(PERIOD_RESET);
  localparam logic [DATA_WIDTH-1:0] ResetData     = ResetValue32[DATA_WIDTH-1:0];
  localparam logic [PERIOD_W-1:0]   ResetPeriod   = PeriodReset32[PERIOD_W-1:0];

  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] blink_en_q, blink_en_d;
  logic [PERIOD_W-1:0]   period_q, period_d;
  logic [PERIOD_W-1:0]   cnt_q, cnt_d;
  logic                  phase_q, phase_d;
  logic [31:0]           readdata_d;
  logic [DATA_WIDTH-1:0] out_d;

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wd_data;
  logic [PERIOD_W-1:0]   wd_period;
  logic                  unused_wd;

  assign wr_en     = chipselect & ~write_n;
  assign wd_data   = writedata[DATA_WIDTH-1:0];
  assign wd_period = writedata[PERIOD_W-1:0];
  // Upper writedata bits are intentionally ignored.
  assign unused_wd = ^writedata;

  always_comb begin
    data_d     = data_q;
    blink_en_d = blink_en_q;
    period_d   = period_q;
    cnt_d      = cnt_q;
    phase_d    = phase_q;

    // Blink engine; a period write overrides the free-running count so a
    // smaller new period never has to wait for a full counter wrap.
    if (wr_en && (address == 3'd2)) begin
      period_d = wd_period;
      cnt_d    = '0;
      phase_d  = 1'b0;
    end else if (cnt_q == period_q) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end else begin
      cnt_d = cnt_q + PERIOD_W'(1);
    end

    if (wr_en) begin
      case (address)
        3'd0:    data_d     = wd_data;
        3'd1:    blink_en_d = wd_data;
        3'd4:    data_d     = data_q | wd_data;
        3'd5:    data_d     = data_q & ~wd_data;
        default: ;
      endcase
    end

    // Built from next-state values so writes and toggles show one cycle later.
    out_d = data_d ^ (blink_en_d & {DATA_WIDTH{phase_d}});

    case (address)
      3'd0:    readdata_d = 32'(data_q);
      3'd1:    readdata_d = 32'(blink_en_q);
      3'd2:    readdata_d = 32'(period_q);
      3'd3:    readdata_d = {31'd0, phase_q};
      default: readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q     <= ResetData;
      blink_en_q <= '0;
      period_q   <= ResetPeriod;
      cnt_q      <= '0;
      phase_q    <= 1'b0;
      readdata   <= '0;
      out_port   <= ResetData;
    end else begin
      data_q     <= data_d;
      blink_en_q <= blink_en_d;
      period_q   <= period_d;
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
      readdata   <= readdata_d;
      out_port   <= out_d;
    end
  end

endmodule

// File: tb/tb_deca_vip_led_pio.sv
// Self-checking bench for deca_vip_led_pio: directed checks with literal
// expectations plus randomized traffic against a behavioural model. The model
// derives the blink phase from elapsed edges since the last restart rather
// than tracking a counter.
module tb_deca_vip_led_pio;

  localparam int unsigned Dw = 8;
  localparam int unsigned Pw = 24;
  localparam logic [7:0]  Rv = 8'h00;
  localparam longint      Pr = 12500000;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  out_port;

  int checks = 0;
  int errors = 0;

  deca_vip_led_pio #(
    .DATA_WIDTH  (Dw),
    .RESET_VALUE (0),
    .PERIOD_W    (Pw),
    .PERIOD_RESET(12500000)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .out_port  (out_port)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  bit          checking = 1'b0;
  longint      edge_idx = 0;
  longint      m_restart = 0;
  longint      m_period = Pr;
  logic [7:0]  m_data = Rv;
  logic [7:0]  m_en = 8'h00;
  logic [31:0] exp_rd;
  logic [7:0]  exp_out;
  logic        pre_phase;

  // Phase after edge x: number of completed half-periods since restart, mod 2.
  function automatic logic phase_after(input longint x);
    return 1'(((x - m_restart) / (m_period + 1)) % 2);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      checking  = 1'b1;
      m_data    = Rv;
      m_en      = 8'h00;
      m_period  = Pr;
      m_restart = edge_idx;
      exp_rd    = 32'd0;
    end else if (checking) begin
      pre_phase = phase_after(edge_idx - 1);
      case (address)
        3'd0:    exp_rd = {24'd0, m_data};
        3'd1:    exp_rd = {24'd0, m_en};
        3'd2:    exp_rd = 32'(m_period);
        3'd3:    exp_rd = {31'd0, pre_phase};
        default: exp_rd = 32'd0;
      endcase
      if (chipselect && !write_n) begin
        case (address)
          3'd0: m_data = writedata[7:0];
          3'd1: m_en   = writedata[7:0];
          3'd2: begin
            m_period  = longint'(writedata[Pw-1:0]);
            m_restart = edge_idx;
          end
          3'd4: m_data = m_data | writedata[7:0];
          3'd5: m_data = m_data & ~writedata[7:0];
          default: ;
        endcase
      end
    end
    exp_out  = m_data ^ (m_en & {8{phase_after(edge_idx)}});
    edge_idx = edge_idx + 1;
    #1;
    if (checking) begin
      checks = checks + 2;
      if (out_port !== exp_out) begin
        errors = errors + 1;
        $display("FAIL model_out_port edge %0d: got %h expected %h", edge_idx - 1, out_port,
                 exp_out);
      end
      if (readdata !== exp_rd) begin
        errors = errors + 1;
        $display("FAIL model_readdata edge %0d: got %h expected %h", edge_idx - 1, readdata,
                 exp_rd);
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] r);
    address = a;
    @(negedge clk);
    r = readdata;
  endtask

  logic [31:0] r;
  logic [31:0] tmp;

  initial begin
    reset      = 1'b1;
    address    = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("reset_out_port", {24'd0, out_port}, 32'h0);
    check("reset_readdata", readdata, 32'h0);
    rd(3'd2, r);
    check("reset_period", r, 32'h00BEBC20);

    // Data write and readback
    wr(3'd0, 32'h0000_00A5);
    check("data_out", {24'd0, out_port}, 32'hA5);
    rd(3'd0, r);
    check("data_read", r, 32'hA5);
    wr(3'd0, 32'hFFFF_FF3C);
    check("data_upper_ignored", {24'd0, out_port}, 32'h3C);

    // Set / clear aliases
    wr(3'd0, 32'hA5);
    wr(3'd4, 32'h0A);
    check("outset_out", {24'd0, out_port}, 32'hAF);
    rd(3'd0, r);
    check("outset_read", r, 32'hAF);
    wr(3'd5, 32'h81);
    rd(3'd0, r);
    check("outclear_read", r, 32'h2E);
    rd(3'd4, r);
    check("read_outset_zero", r, 32'h0);
    rd(3'd5, r);
    check("read_outclear_zero", r, 32'h0);
    rd(3'd6, r);
    check("read_reserved_zero", r, 32'h0);

    // Blink with half-period 4 cycles
    wr(3'd0, 32'h0);
    wr(3'd1, 32'h1);
    wr(3'd2, 32'd3);
    for (int j = 0; j < 12; j++) begin
      check($sformatf("blink_p3_j%0d", j), {24'd0, out_port}, 32'((j / 4) % 2));
      @(negedge clk);
    end

    // DATA write on the toggle edge: both visible
    wr(3'd2, 32'd3);
    repeat (3) @(negedge clk);
    wr(3'd0, 32'h10);
    check("data_on_toggle", {24'd0, out_port}, 32'h11);
    // Clear BLINK_EN while phase is 1
    wr(3'd1, 32'h0);
    check("clear_en_phase1", {24'd0, out_port}, 32'h10);

    // Half-period of one cycle
    wr(3'd1, 32'h1);
    wr(3'd2, 32'd0);
    for (int j = 0; j < 4; j++) begin
      check($sformatf("blink_p0_j%0d", j), {24'd0, out_port}, 32'h10 | 32'(j % 2));
      @(negedge clk);
    end

    // Reset mid-blink
    wr(3'd1, 32'hFF);
    wr(3'd2, 32'd3);
    repeat (4) @(negedge clk);
    check("phase1_all_en", {24'd0, out_port}, 32'hEF);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midreset_out", {24'd0, out_port}, 32'h0);
    rd(3'd3, r);
    check("midreset_status", r, 32'h0);
    rd(3'd1, r);
    check("midreset_blink_en", r, 32'h0);

    // Randomized traffic, checked every cycle by the model
    for (int i = 0; i < 3000; i++) begin
      tmp        = $urandom();
      address    = 3'($urandom_range(0, 7));
      chipselect = 1'($urandom_range(0, 1));
      write_n    = ($urandom_range(0, 2) == 0);
      if (address == 3'd2) writedata = {tmp[31:24], 21'd0, tmp[2:0]};
      else writedata = tmp;
      reset = ($urandom_range(0, 63) == 0);
      @(negedge clk);
    end
    reset      = 1'b0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
